// File: rtl/tug_field.sv
// tug_field: tug-of-war playfield controller.
// One lit position moves one step per accepted press toward the pressing
// player. Pushing it off an edge scores a round win, holds the win indication
// for HOLD_CYCLES cycles, then re-centres the light.
// Optional feature macro: TUG_FIELD_MATCH_LIMIT_EN
//   defined   -> reaching MATCH_POINTS ends the match (DONE, match_over = 1),
//                scores saturate at MATCH_POINTS
//   undefined -> scores wrap modulo 2^SCORE_W, match_over tied to 0
module tug_field #(
  parameter int NUM_LIGHTS   = 9,
  parameter int SCORE_W      = 3,
  parameter int HOLD_CYCLES  = 4,
  parameter int MATCH_POINTS = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  round_restart,
  input  logic                  L,
  input  logic                  R,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  win_l,
  output logic                  win_r,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  match_over
);

  localparam int POS_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'((NUM_LIGHTS - 1) / 2);
  localparam logic [POS_W-1:0]   POS_LEFT   = POS_W'(NUM_LIGHTS - 1);
  localparam logic [POS_W-1:0]   POS_RIGHT  = '0;
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MATCH_SCORE = SCORE_W'(MATCH_POINTS);

`ifdef TUG_FIELD_MATCH_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    HOLD_L = 2'd1,
    HOLD_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [POS_W-1:0]   pos, pos_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SCORE_W-1:0] score_l_n, score_r_n;
  logic               mv_l, mv_r;

  // A simultaneous press from both players cancels out.
  assign mv_l = L & ~R;
  assign mv_r = R & ~L;

  // Round-win score update: wraps when unlimited, saturates at the match score
  // when the match limit is in force.
  function automatic logic [SCORE_W-1:0] bump(input logic [SCORE_W-1:0] s);
    if (LIMIT_EN && (s >= MATCH_SCORE)) return s;
    return s + SCORE_W'(1);
  endfunction

  // Next-state decode: round_restart first, then the per-state play rules.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_n   = state;
    pos_n     = pos;
    cnt_n     = cnt;
    score_l_n = score_l;
    score_r_n = score_r;

    if (round_restart && (state != DONE)) begin
      state_n = PLAY;
      pos_n   = POS_CENTRE;
      cnt_n   = '0;
    end else begin
      case (state)
        PLAY: begin
          if (mv_l) begin
            if (pos == POS_LEFT) begin
              score_l_n = bump(score_l);
              state_n   = HOLD_L;
              cnt_n     = HOLD_LOAD;
            end else begin
              pos_n = pos + POS_W'(1);
            end
          end else if (mv_r) begin
            if (pos == POS_RIGHT) begin
              score_r_n = bump(score_r);
              state_n   = HOLD_R;
              cnt_n     = HOLD_LOAD;
            end else begin
              pos_n = pos - POS_W'(1);
            end
          end
        end

        HOLD_L, HOLD_R: begin
          if (cnt == '0) begin
            pos_n = POS_CENTRE;
            if (LIMIT_EN &&
                (((state == HOLD_L) && (score_l == MATCH_SCORE)) ||
                 ((state == HOLD_R) && (score_r == MATCH_SCORE)))) begin
              state_n = DONE;
            end else begin
              state_n = PLAY;
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end

        default: begin
          pos_n = POS_CENTRE;
        end
      endcase
    end
  end

  // State and registered outputs, all derived from the next-state values so
  // that outputs change on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state      <= PLAY;
      pos        <= POS_CENTRE;
      cnt        <= '0;
      score_l    <= '0;
      score_r    <= '0;
      lights     <= NUM_LIGHTS'(1) << POS_CENTRE;
      win_l      <= 1'b0;
      win_r      <= 1'b0;
      match_over <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      cnt        <= cnt_n;
      score_l    <= score_l_n;
      score_r    <= score_r_n;
      lights     <= ((state_n == HOLD_L) || (state_n == HOLD_R)) ?
                    '0 : (NUM_LIGHTS'(1) << pos_n);
      win_l      <= (state_n == HOLD_L);
      win_r      <= (state_n == HOLD_R);
      match_over <= LIMIT_EN && (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_tug_field.sv
// tb_tug_field: randomized and directed stimulus for tug_field, checked every
// cycle against a round-level behavioural model of the playfield.
// Honours TUG_FIELD_MATCH_LIMIT_EN (uses MATCH_POINTS = 2 when defined).
module tb_tug_field;

  localparam int NL   = 9;
  localparam int SW   = 3;
  localparam int HOLD = 4;
`ifdef TUG_FIELD_MATCH_LIMIT_EN
  localparam int MP   = 2;
`else
  localparam int MP   = 7;
`endif
  localparam int CTR  = (NL - 1) / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          round_restart = 1'b0;
  logic          L = 1'b0;
  logic          R = 1'b0;
  logic [NL-1:0] lights;
  logic          win_l, win_r;
  logic [SW-1:0] score_l, score_r;
  logic          match_over;

  tug_field #(
    .NUM_LIGHTS  (NL),
    .SCORE_W     (SW),
    .HOLD_CYCLES (HOLD),
    .MATCH_POINTS(MP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .round_restart(round_restart),
    .L            (L),
    .R            (R),
    .lights       (lights),
    .win_l        (win_l),
    .win_r        (win_r),
    .score_l      (score_l),
    .score_r      (score_r),
    .match_over   (match_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: light position, remaining win-hold cycles, who won,
  // running scores and whether the match has been decided.
  int  m_pos = CTR;
  int  m_hold = 0;
  bit  m_left_won = 1'b0;
  int  m_sl = 0;
  int  m_sr = 0;
  bit  m_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = CTR; m_hold = 0; m_sl = 0; m_sr = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_pos = CTR;
    end else if (round_restart) begin
      m_pos = CTR; m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) begin
        m_pos = CTR;
`ifdef TUG_FIELD_MATCH_LIMIT_EN
        if ((m_left_won ? m_sl : m_sr) == MP) m_done = 1'b1;
`endif
      end
    end else if (L && !R) begin
      if (m_pos == NL - 1) begin
        m_sl = (m_sl + 1) % (1 << SW); m_hold = HOLD; m_left_won = 1'b1;
      end else m_pos = m_pos + 1;
    end else if (R && !L) begin
      if (m_pos == 0) begin
        m_sr = (m_sr + 1) % (1 << SW); m_hold = HOLD; m_left_won = 1'b0;
      end else m_pos = m_pos - 1;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NL-1:0] exp_lights;
      exp_lights = (m_hold > 0) ? '0 : (NL'(1) << m_pos);
      check("lights", 32'(lights), 32'(exp_lights));
      check("win_l", 32'(win_l), 32'((m_hold > 0) && m_left_won));
      check("win_r", 32'(win_r), 32'((m_hold > 0) && !m_left_won));
      check("score_l", 32'(score_l), 32'(m_sl));
      check("score_r", 32'(score_r), 32'(m_sr));
      check("match_over", 32'(match_over), 32'(m_done));
    end
  end

  // Apply one cycle of inputs (called at a falling edge), return at the next
  // falling edge with the resulting outputs visible.
  task automatic step(input bit l, input bit r, input bit rr, input bit rs);
    L = l; R = r; round_restart = rr; reset = rs;
    @(negedge clk);
  endtask

  task automatic win_left_round();
    for (int i = 0; i < CTR + 1; i++) step(1, 0, 0, 0);
    for (int i = 0; i < HOLD; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_lights", 32'(lights), 32'(9'b000010000));
    check("rst_scores", 32'({score_l, score_r}), 32'd0);

    // Walk the light to the left edge.
    step(1, 0, 0, 0); check("walk1", 32'(lights), 32'(9'b000100000));
    step(1, 0, 0, 0); check("walk2", 32'(lights), 32'(9'b001000000));
    step(1, 0, 0, 0); check("walk3", 32'(lights), 32'(9'b010000000));
    step(1, 0, 0, 0); check("walk4", 32'(lights), 32'(9'b100000000));

    // Push off the left edge; R presses during the hold are ignored.
    step(1, 0, 0, 0);
    check("score_edge_lights", 32'(lights), 32'd0);
    check("score_edge_win_l", 32'(win_l), 32'd1);
    check("score_edge_score_l", 32'(score_l), 32'd1);
    for (int i = 0; i < HOLD - 1; i++) begin
      step(0, 1, 0, 0);
      check("hold_win_l", 32'(win_l), 32'd1);
    end
    step(0, 0, 0, 0);
    check("recentre_lights", 32'(lights), 32'(9'b000010000));
    check("recentre_win_l", 32'(win_l), 32'd0);

    // Simultaneous presses and idle cycles do not move the light.
    step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check("both_held", 32'(lights), 32'(9'b000001000));

    // Right win, then abort the hold with round_restart.
    for (int i = 0; i < CTR; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("r_win", 32'(win_r), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("rr_lights", 32'(lights), 32'(9'b000010000));
    check("rr_win_r", 32'(win_r), 32'd0);
    check("rr_score_r", 32'(score_r), 32'd1);

    // Mid-round reset clears scores.
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("reset_scores", 32'({score_l, score_r}), 32'd0);
    check("reset_lights", 32'(lights), 32'(9'b000010000));

    // Randomized play with occasional restarts and resets.
    for (int blk = 0; blk < 15; blk++) begin
      int bias;
      bias = $urandom_range(2, 8);
      for (int i = 0; i < 200; i++) begin
        step(($urandom % 10) < bias, ($urandom % 10) >= bias,
             $urandom_range(0, 59) == 0, $urandom_range(0, 249) == 0);
      end
    end

    step(0, 0, 0, 1);
`ifdef TUG_FIELD_MATCH_LIMIT_EN
    win_left_round();
    check("match_one_win", 32'(match_over), 32'd0);
    win_left_round();
    check("match_over_set", 32'(match_over), 32'd1);
    check("match_lights", 32'(lights), 32'(9'b000010000));
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("done_frozen_lights", 32'(lights), 32'(9'b000010000));
    check("done_frozen_score", 32'(score_l), 32'd2);
    step(0, 0, 0, 1);
    check("done_reset", 32'(match_over), 32'd0);
`else
    for (int k = 1; k <= 8; k++) begin
      win_left_round();
      check("wrap_score_l", 32'(score_l), 32'(k % 8));
      check("wrap_match_over", 32'(match_over), 32'd0);
    end
    check("wrap_final_zero", 32'(score_l), 32'd0);
`endif
    step(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
